// File: rtl/nes_controller_port.sv
// NES standard-controller ports at $4016/$4017: HID keycodes are synchronised, decoded
// into button vectors, latched on the CPU strobe and shifted out one bit per read.
module nes_controller_port #(
   parameter logic [7:0] KEY_A      = 8'h0D,
   parameter logic [7:0] KEY_B      = 8'h0E,
   parameter logic [7:0] KEY_SELECT = 8'h2C,
   parameter logic [7:0] KEY_START  = 8'h28,
   parameter logic [7:0] KEY_UP     = 8'h1A,
   parameter logic [7:0] KEY_DOWN   = 8'h16,
   parameter logic [7:0] KEY_LEFT   = 8'h04,
   parameter logic [7:0] KEY_RIGHT  = 8'h07,
   parameter logic [7:0] OPEN_BUS   = 8'h40
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [7:0]  keycode1,
   input  logic [7:0]  keycode2,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_dout_en,
   output logic [7:0]  buttons1,
   output logic [7:0]  buttons2
);

   logic [7:0] kc1_meta_q, kc1_meta_d, kc1_sync_q, kc1_sync_d;
   logic [7:0] kc2_meta_q, kc2_meta_d, kc2_sync_q, kc2_sync_d;
   logic [7:0] btn1_q, btn1_d, btn2_q, btn2_d;
   logic [7:0] sh1_q, sh1_d, sh2_q, sh2_d;
   logic       strobe_q, strobe_d;
   logic       wr_strobe, rd_port1, rd_port2;
   logic       unused_din;

   assign unused_din = ^cpu_din[7:1];

   function automatic logic [7:0] decode_key(input logic [7:0] kc);
      logic [7:0] v;
      v = 8'h00;
      if      (kc == KEY_A)      v = 8'h01;
      else if (kc == KEY_B)      v = 8'h02;
      else if (kc == KEY_SELECT) v = 8'h04;
      else if (kc == KEY_START)  v = 8'h08;
      else if (kc == KEY_UP)     v = 8'h10;
      else if (kc == KEY_DOWN)   v = 8'h20;
      else if (kc == KEY_LEFT)   v = 8'h40;
      else if (kc == KEY_RIGHT)  v = 8'h80;
      return v;
   endfunction

   always_comb begin
      kc1_meta_d = keycode1;
      kc1_sync_d = kc1_meta_q;
      btn1_d     = decode_key(kc1_sync_q);
      kc2_meta_d = keycode2;
      kc2_sync_d = kc2_meta_q;
      btn2_d     = decode_key(kc2_sync_q);

      wr_strobe = cpu_wr && (cpu_addr == 16'h4016);
      rd_port1  = cpu_rd && (cpu_addr == 16'h4016);
      rd_port2  = cpu_rd && (cpu_addr == 16'h4017);
      strobe_d  = wr_strobe ? cpu_din[0] : strobe_q;

      // The incoming strobe value decides the edge; a falling strobe just holds.
      sh1_d = sh1_q;
      sh2_d = sh2_q;
      if (strobe_d) begin
         sh1_d = btn1_q;
         sh2_d = btn2_q;
      end else if (!strobe_q) begin
         if (rd_port1) sh1_d = {1'b1, sh1_q[7:1]};
         if (rd_port2) sh2_d = {1'b1, sh2_q[7:1]};
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         kc1_meta_q <= 8'h00;
         kc1_sync_q <= 8'h00;
         kc2_meta_q <= 8'h00;
         kc2_sync_q <= 8'h00;
         btn1_q     <= 8'h00;
         btn2_q     <= 8'h00;
         sh1_q      <= 8'h00;
         sh2_q      <= 8'h00;
         strobe_q   <= 1'b0;
      end else begin
         kc1_meta_q <= kc1_meta_d;
         kc1_sync_q <= kc1_sync_d;
         kc2_meta_q <= kc2_meta_d;
         kc2_sync_q <= kc2_sync_d;
         btn1_q     <= btn1_d;
         btn2_q     <= btn2_d;
         sh1_q      <= sh1_d;
         sh2_q      <= sh2_d;
         strobe_q   <= strobe_d;
      end
   end

   // With strobe high the A button is reported live instead of the shift register.
   always_comb begin
      cpu_dout    = 8'h00;
      cpu_dout_en = rd_port1 || rd_port2;
      if (rd_port1)
         cpu_dout = {OPEN_BUS[7:1], strobe_q ? btn1_q[0] : sh1_q[0]};
      else if (rd_port2)
         cpu_dout = {OPEN_BUS[7:1], strobe_q ? btn2_q[0] : sh2_q[0]};
   end

   assign buttons1 = btn1_q;
   assign buttons2 = btn2_q;

endmodule

// File: tb/tb_nes_controller_port.sv
// Bench for nes_controller_port: directed scenarios plus random bus traffic against a
// model that tracks latched button vectors and a per-port read position.
module tb_nes_controller_port;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [7:0]  keycode1, keycode2;
   logic [15:0] cpu_addr;
   logic        cpu_wr, cpu_rd;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        cpu_dout_en;
   logic [7:0]  buttons1, buttons2;

   int n_checks = 0;
   int n_fail   = 0;

   nes_controller_port dut (
      .Clk(Clk), .Reset(Reset), .keycode1(keycode1), .keycode2(keycode2),
      .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_dout_en(cpu_dout_en),
      .buttons1(buttons1), .buttons2(buttons2)
   );

   always #5 Clk = ~Clk;

   // Reference model
   logic [7:0] key_tab [8] = '{8'h0D, 8'h0E, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07};
   logic [7:0] kq1 [$];
   logic [7:0] kq2 [$];
   logic       m_strobe;
   logic [7:0] m_lat [2];
   int         m_idx [2];

   function automatic logic [7:0] m_decode(input logic [7:0] kc);
      for (int i = 0; i < 8; i++)
         if (kc == key_tab[i]) return 8'(1 << i);
      return 8'h00;
   endfunction

   function automatic logic [7:0] m_btn(input int p);
      return (p == 0) ? m_decode(kq1[0]) : m_decode(kq2[0]);
   endfunction

   function automatic logic m_read_bit(input int p);
      logic [7:0] b;
      logic [7:0] l;
      b = m_btn(p);
      l = m_lat[p];
      if (m_strobe) return b[0];
      if (m_idx[p] < 8) return l[m_idx[p]];
      return 1'b1;
   endfunction

   task automatic model_reset();
      kq1 = '{8'h00, 8'h00, 8'h00};
      kq2 = '{8'h00, 8'h00, 8'h00};
      m_strobe = 1'b0;
      m_lat[0] = 8'h00; m_lat[1] = 8'h00;
      m_idx[0] = 0;     m_idx[1] = 0;
   endtask

   task automatic model_edge(input logic wr, input logic rd, input logic [15:0] addr,
                             input logic [7:0] din, input logic [7:0] kc1, input logic [7:0] kc2);
      logic [7:0] b0, b1;
      logic ns;
      b0 = m_btn(0);
      b1 = m_btn(1);
      ns = (wr && addr == 16'h4016) ? din[0] : m_strobe;
      if (ns) begin
         m_lat[0] = b0; m_lat[1] = b1;
         m_idx[0] = 0;  m_idx[1] = 0;
      end else if (!m_strobe) begin
         if (rd && addr == 16'h4016 && m_idx[0] < 8) m_idx[0]++;
         if (rd && addr == 16'h4017 && m_idx[1] < 8) m_idx[1]++;
      end
      m_strobe = ns;
      kq1.push_back(kc1); void'(kq1.pop_front());
      kq2.push_back(kc2); void'(kq2.pop_front());
   endtask

   // One bus cycle: drive, sample combinational read data, advance DUT and model.
   task automatic do_cycle(input logic wr, input logic rd, input logic [15:0] addr,
                           input logic [7:0] din, output logic [7:0] got_d,
                           output logic [7:0] exp_d, output logic got_e, output logic exp_e);
      cpu_wr = wr; cpu_rd = rd; cpu_addr = addr; cpu_din = din;
      #1;
      if (rd && (addr == 16'h4016 || addr == 16'h4017)) begin
         exp_e = 1'b1;
         exp_d = {7'h20, m_read_bit((addr == 16'h4017) ? 1 : 0)};
      end else begin
         exp_e = 1'b0;
         exp_d = 8'h00;
      end
      got_d = cpu_dout;
      got_e = cpu_dout_en;
      @(posedge Clk);
      model_edge(wr, rd, addr, din, keycode1, keycode2);
      #1;
      cpu_wr = 1'b0; cpu_rd = 1'b0;
   endtask

   task automatic idle(input int n);
      logic [7:0] gd, ed;
      logic ge, ee;
      for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 16'h0000, 8'h00, gd, ed, ge, ee);
   endtask

   task automatic strobe_pulse();
      logic [7:0] gd, ed;
      logic ge, ee;
      do_cycle(1'b1, 1'b0, 16'h4016, 8'h01, gd, ed, ge, ee);
      do_cycle(1'b1, 1'b0, 16'h4016, 8'h00, gd, ed, ge, ee);
   endtask

   task automatic apply_reset();
      Reset = 1'b1;
      @(posedge Clk);
      model_reset();
      #1;
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] gd, ed;
      logic ge, ee;
      apply_reset();
      n_checks++;
      if (buttons1 !== 8'h00 || buttons2 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_buttons: got %h/%h want 00/00", buttons1, buttons2);
      end
      do_cycle(1'b0, 1'b0, 16'h4016, 8'h00, gd, ed, ge, ee);
      n_checks++;
      if (gd !== 8'h00 || ge !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_dout: got %h en %b want 00 en 0", gd, ge);
      end
      do_cycle(1'b0, 1'b1, 16'h4016, 8'h00, gd, ed, ge, ee);
      n_checks++;
      if (gd !== 8'h40 || ge !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_read: got %h en %b want 40 en 1", gd, ge);
      end
   endtask

   task automatic test_decode();
      logic [7:0] kc;
      keycode1 = 8'h0D;
      idle(2);
      n_checks++;
      if (buttons1 !== 8'h00) begin
         n_fail++;
         $display("FAIL decode_latency_early: got %h want 00", buttons1);
      end
      idle(1);
      n_checks++;
      if (buttons1 !== 8'h01) begin
         n_fail++;
         $display("FAIL decode_A: got %h want 01", buttons1);
      end
      keycode1 = 8'h00;
      idle(3);
      n_checks++;
      if (buttons1 !== 8'h00) begin
         n_fail++;
         $display("FAIL decode_release: got %h want 00", buttons1);
      end
      for (int i = 0; i < 16; i++) begin
         kc = ($urandom_range(0, 3) != 0) ? key_tab[$urandom_range(0, 7)] : 8'($urandom);
         if (i % 2 == 0) keycode1 = kc; else keycode2 = kc;
         idle(3);
         n_checks++;
         if (buttons1 !== m_btn(0) || buttons2 !== m_btn(1)) begin
            n_fail++;
            $display("FAIL decode_random: got %h/%h want %h/%h", buttons1, buttons2,
                     m_btn(0), m_btn(1));
         end
      end
   endtask

   task automatic test_serial();
      logic [7:0] gd, ed;
      logic ge, ee;
      logic exp_seq [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
      keycode1 = 8'h28;
      idle(3);
      strobe_pulse();
      for (int i = 0; i < 10; i++) begin
         do_cycle(1'b0, 1'b1, 16'h4016, 8'h00, gd, ed, ge, ee);
         n_checks++;
         if (gd[0] !== exp_seq[i] || gd[7:1] !== 7'h20 || gd !== ed || ge !== 1'b1) begin
            n_fail++;
            $display("FAIL serial_start read %0d: got %h en %b want bit0 %b (model %h)",
                     i, gd, ge, exp_seq[i], ed);
         end
      end
   endtask

   task automatic test_port2();
      logic [7:0] gd, ed;
      logic ge, ee;
      keycode2 = 8'h07;
      idle(3);
      strobe_pulse();
      for (int i = 0; i < 8; i++) begin
         do_cycle(1'b0, 1'b1, 16'h4017, 8'h00, gd, ed, ge, ee);
         n_checks++;
         if (gd !== ed || ge !== 1'b1 || gd[0] !== ((i == 7) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL port2_read %0d: got %h en %b want %h", i, gd, ge, ed);
         end
      end
      do_cycle(1'b0, 1'b1, 16'h4016, 8'h00, gd, ed, ge, ee);
      n_checks++;
      if (gd !== ed || gd[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL port1_unaffected: got %h want %h", gd, ed);
      end
   endtask

   task automatic test_live();
      logic [7:0] gd, ed;
      logic ge, ee;
      logic want;
      do_cycle(1'b1, 1'b0, 16'h4016, 8'h01, gd, ed, ge, ee);
      for (int i = 0; i < 6; i++) begin
         keycode1 = (i % 2 == 0) ? 8'h0D : 8'h00;
         want = (i % 2 == 0);
         idle(3);
         for (int r = 0; r < 2; r++) begin
            do_cycle(1'b0, 1'b1, 16'h4016, 8'h00, gd, ed, ge, ee);
            n_checks++;
            if (gd[0] !== want || gd !== ed) begin
               n_fail++;
               $display("FAIL live_A %0d.%0d: got %h want bit0 %b (model %h)", i, r, gd, want, ed);
            end
         end
      end
      do_cycle(1'b1, 1'b0, 16'h4016, 8'h00, gd, ed, ge, ee);
   endtask

   task automatic test_back_to_back();
      logic [7:0] gd, ed;
      logic ge, ee;
      logic exp_seq [4] = '{0, 0, 1, 0};
      keycode1 = 8'h2C;
      idle(3);
      strobe_pulse();
      for (int i = 0; i < 4; i++) begin
         do_cycle((i == 2), 1'b1, 16'h4016, 8'h00, gd, ed, ge, ee);
         n_checks++;
         if (gd[0] !== exp_seq[i] || gd !== ed) begin
            n_fail++;
            $display("FAIL wr_rd_same_cycle read %0d: got %h want bit0 %b (model %h)",
                     i, gd, exp_seq[i], ed);
         end
      end
      do_cycle(1'b1, 1'b1, 16'h4016, 8'h01, gd, ed, ge, ee);
      n_checks++;
      if (gd !== ed) begin
         n_fail++;
         $display("FAIL wr1_rd_same_cycle: got %h want %h", gd, ed);
      end
      do_cycle(1'b1, 1'b0, 16'h4016, 8'h00, gd, ed, ge, ee);
      do_cycle(1'b0, 1'b1, 16'h4016, 8'h00, gd, ed, ge, ee);
      n_checks++;
      if (gd !== ed || gd[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reload_after_wr_rd: got %h want %h", gd, ed);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] gd, ed;
      logic ge, ee;
      keycode1 = 8'h0D;
      idle(3);
      strobe_pulse();
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 16'h4016, 8'h00, gd, ed, ge, ee);
      apply_reset();
      do_cycle(1'b0, 1'b1, 16'h4016, 8'h00, gd, ed, ge, ee);
      n_checks++;
      if (gd !== 8'h40 || gd !== ed) begin
         n_fail++;
         $display("FAIL reset_mid_read: got %h want 40", gd);
      end
      idle(3);
      do_cycle(1'b1, 1'b0, 16'h4017, 8'h01, gd, ed, ge, ee);
      do_cycle(1'b1, 1'b0, 16'h4000, 8'h01, gd, ed, ge, ee);
      do_cycle(1'b0, 1'b1, 16'h4016, 8'h00, gd, ed, ge, ee);
      n_checks++;
      if (gd !== 8'h40 || gd !== ed) begin
         n_fail++;
         $display("FAIL wr4017_no_strobe: got %h want 40", gd);
      end
   endtask

   task automatic test_random();
      logic [7:0] gd, ed;
      logic ge, ee;
      logic [15:0] a;
      int sel;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0)
            keycode1 = ($urandom_range(0, 3) != 0) ? key_tab[$urandom_range(0, 7)] : 8'($urandom);
         if ($urandom_range(0, 7) == 0)
            keycode2 = ($urandom_range(0, 3) != 0) ? key_tab[$urandom_range(0, 7)] : 8'($urandom);
         sel = $urandom_range(0, 4);
         a = (sel < 2) ? 16'h4016 : (sel < 4) ? 16'h4017 : 16'($urandom);
         do_cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1), a,
                  8'($urandom), gd, ed, ge, ee);
         n_checks++;
         if (gd !== ed || ge !== ee) begin
            n_fail++;
            $display("FAIL random_read %0d addr %h: got %h en %b want %h en %b",
                     i, a, gd, ge, ed, ee);
         end
         n_checks++;
         if (buttons1 !== m_btn(0) || buttons2 !== m_btn(1)) begin
            n_fail++;
            $display("FAIL random_buttons %0d: got %h/%h want %h/%h", i, buttons1, buttons2,
                     m_btn(0), m_btn(1));
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      keycode1 = 8'h00; keycode2 = 8'h00;
      cpu_addr = 16'h0000; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_din = 8'h00;
      model_reset();
      test_reset();
      test_decode();
      apply_reset();
      keycode1 = 8'h00; keycode2 = 8'h00;
      test_serial();
      test_port2();
      test_live();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
